ifetch_queue: RTL

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue_pkg.sv | 11 +
 rtl/ifetch_queue_fifo.sv | 75 +++++++
 rtl/ifetch_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: FSM encodings and default widths.
package ifetch_queue_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INS_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ifq_state_e;
endpackage

// File: rtl/ifetch_queue_fifo.sv
// Fetch-queue storage: circular buffer with synchronous flush and a registered head entry.
module ifq_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr, w_rd_nxt, w_wr_nxt;
  logic [AW:0]      r_cnt, w_cnt_pop, w_cnt_nxt;
  logic [WIDTH-1:0] r_head, w_head_nxt;
  logic             w_pop, w_push;

  assign w_pop     = i_pop && (r_cnt != '0);
  assign w_push    = i_push && (r_cnt != FULL);
  assign w_rd_nxt  = w_pop ? r_rd + PTR_ONE : r_rd;
  assign w_wr_nxt  = w_push ? r_wr + PTR_ONE : r_wr;
  assign w_cnt_pop = w_pop ? r_cnt - CNT_ONE : r_cnt;
  assign w_cnt_nxt = w_push ? w_cnt_pop + CNT_ONE : w_cnt_pop;

  // The head register must track what the array will hold at w_rd_nxt after this edge;
  // when the pushed entry becomes the only one, it bypasses the array.
  always_comb begin
    w_head_nxt = r_head;
    if (i_flush)
      w_head_nxt = '0;
    else if (w_push && (w_cnt_pop == '0))
      w_head_nxt = i_data;
    else if (w_cnt_pop != '0)
      w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
    end else if (i_en) begin
      r_head <= w_head_nxt;
      if (i_flush) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        r_rd  <= w_rd_nxt;
        r_wr  <= w_wr_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_en && w_push && !i_flush)
      r_mem[r_wr] <= i_data;
  end

  assign o_valid = (r_cnt != '0);
  assign o_head  = r_head;
  assign o_count = r_cnt;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding icache request, branch-predicted next PC,
// and a small queue feeding the decoder; redirects flush and drop stale responses.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             rdy_in,
  output logic             ic_req_valid,
  output logic [XLEN-1:0]  ic_req_pc,
  input  logic             ic_resp_valid,
  input  logic [INS_W-1:0] ic_resp_ins,
  output logic [XLEN-1:0]  bp_pc,
  output logic [INS_W-1:0] bp_ins,
  input  logic [XLEN-1:0]  bp_pred_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [INS_W-1:0] dec_ins,
  output logic [XLEN-1:0]  dec_pc,
  output logic [XLEN-1:0]  dec_pred_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc
);
  localparam int            EW       = INS_W + 2 * XLEN;
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ifq_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_req_valid;
  logic [XLEN-1:0] r_req_pc;
  logic            w_req, w_enq;
  logic [CW-1:0]   w_count;
  logic [EW-1:0]   w_head;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_enq       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!redirect_valid && (w_count < FULL_CNT)) begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ic_resp_valid) begin
          w_enq       = !redirect_valid;
          w_state_nxt = ST_IDLE;
        end else if (redirect_valid) begin
          w_state_nxt = ST_DROP;
        end
      end
      // The stale response always retires DROP, even alongside a new redirect,
      // since the icache answers each request exactly once.
      ST_DROP: begin
        if (ic_resp_valid)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pc_nxt = redirect_valid ? redirect_pc : (w_enq ? bp_pred_pc : r_pc);

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_valid <= w_req;
      if (w_req)
        r_req_pc <= r_pc;
    end
  end

  ifq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rstn_in),
    .i_en    (rdy_in),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_data  ({ic_resp_ins, r_pc, bp_pred_pc}),
    .i_pop   (dec_ready),
    .o_valid (dec_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign {dec_ins, dec_pc, dec_pred_pc} = w_head;
  assign ic_req_valid = r_req_valid;
  assign ic_req_pc    = r_req_pc;
  assign bp_pc        = r_pc;
  assign bp_ins       = ic_resp_ins;
endmodule
